step_scheduler: RTL

STEP_SCHEDULER -- requirements
Module: step_scheduler

---
 rtl/step_sched_pkg.sv | 16 +
 rtl/step_timer.sv | 39 +++
 rtl/step_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/step_sched_pkg.sv
// Shared FSM encoding and default constants for the step scheduler.
package step_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIR_SETUP = 2'd1,
        ST_STEP_HIGH = 2'd2,
        ST_STEP_LOW  = 2'd3
    } sched_state_e;

    localparam int unsigned DEF_COUNT_BITS  = 32;
    localparam int unsigned DEF_TIMER_BITS  = 16;
    localparam int unsigned DEF_DEADBAND    = 1;
    localparam int unsigned DEF_STALL_STEPS = 8;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; a phase loaded with N lasts max(N,1) cycles.
module step_timer
    import step_sched_pkg::*;
#(
    parameter int unsigned TIMER_BITS = DEF_TIMER_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [TIMER_BITS-1:0] load_val_i,
    output logic                  expire_o
);

    logic [TIMER_BITS-1:0] count_q;
    logic [TIMER_BITS-1:0] count_d;

    // Load on phase entry, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_BITS'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Last cycle of the current phase (0 and 1 both mean one cycle).
    assign expire_o = (count_q <= TIMER_BITS'(1));

endmodule

// File: rtl/step_scheduler.sv
// Step/dir pulse scheduler: drives a stepper toward a captured target with stall detection.
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int unsigned COUNT_BITS  = DEF_COUNT_BITS,
    parameter int unsigned TIMER_BITS  = DEF_TIMER_BITS,
    parameter int unsigned DEADBAND    = DEF_DEADBAND,
    parameter int unsigned STALL_STEPS = DEF_STALL_STEPS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [COUNT_BITS-1:0] position,
    input  logic signed [COUNT_BITS-1:0] target,
    input  logic                         target_valid,
    output logic                         target_ready,
    input  logic                         enable,
    input  logic        [TIMER_BITS-1:0] pulse_width,
    input  logic        [TIMER_BITS-1:0] step_period,
    input  logic        [TIMER_BITS-1:0] dir_setup,
    output logic                         step,
    output logic                         dir,
    output logic                         busy,
    output logic                         at_target,
    output logic                         fault
);

    localparam int unsigned EW = COUNT_BITS + 1;
    localparam int unsigned SW = $clog2(STALL_STEPS + 1);

    sched_state_e                 state_q, state_d;
    logic                         step_q, step_d;
    logic                         dir_q, dir_d;
    logic                         fault_q, fault_d;
    logic signed [COUNT_BITS-1:0] target_q, target_d;
    logic signed [COUNT_BITS-1:0] pos_prev_q;
    logic        [SW-1:0]         stall_q, stall_d;

    logic signed [EW-1:0]         err_c;
    logic        [EW-1:0]         abs_err_c;
    logic                         in_band_c;
    logic                         handshake_c;
    logic        [TIMER_BITS-1:0] low_len_c;
    logic                         tmr_load_c;
    logic        [TIMER_BITS-1:0] tmr_val_c;
    logic                         tmr_expire_c;

    // Error is one bit wider than the operands so it cannot wrap.
    assign err_c       = {target_q[COUNT_BITS-1], target_q} - {position[COUNT_BITS-1], position};
    assign abs_err_c   = err_c[EW-1] ? EW'(-err_c) : EW'(err_c);
    assign in_band_c   = (abs_err_c <= EW'(DEADBAND));
    assign handshake_c = target_valid & target_ready;
    assign low_len_c   = (step_period > pulse_width) ? (step_period - pulse_width) : '0;

    assign target_ready = (state_q == ST_IDLE) || (state_q == ST_STEP_LOW);
    assign busy         = (state_q != ST_IDLE);
    assign at_target    = in_band_c;
    assign step         = step_q;
    assign dir          = dir_q;
    assign fault        = fault_q;

    step_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .expire_o   (tmr_expire_c)
    );

    // Next-state, phase timer loads and direction changes.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !fault_q && !in_band_c) begin
                    tmr_load_c = 1'b1;
                    if (!err_c[EW-1] != dir_q) begin
                        dir_d     = ~dir_q;
                        tmr_val_c = dir_setup;
                        state_d   = ST_DIR_SETUP;
                    end else begin
                        tmr_val_c = pulse_width;
                        state_d   = ST_STEP_HIGH;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = pulse_width;
                    state_d    = ST_STEP_HIGH;
                end
            end
            ST_STEP_HIGH: begin
                if (tmr_expire_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = low_len_c;
                    state_d    = ST_STEP_LOW;
                end
            end
            ST_STEP_LOW: begin
                if (tmr_expire_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step output, target capture, stall counting and sticky fault.
    always_comb begin
        step_d   = (state_d == ST_STEP_HIGH);
        target_d = handshake_c ? target : target_q;
        stall_d  = stall_q;
        if (handshake_c || (position != pos_prev_q)) begin
            stall_d = '0;
        end else if ((state_d == ST_STEP_HIGH) && (state_q != ST_STEP_HIGH)
                     && (stall_q < SW'(STALL_STEPS))) begin
            stall_d = stall_q + SW'(1);
        end
        fault_d = handshake_c ? 1'b0 : (fault_q | (stall_d >= SW'(STALL_STEPS)));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            fault_q    <= 1'b0;
            target_q   <= '0;
            stall_q    <= '0;
            pos_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            fault_q    <= fault_d;
            target_q   <= target_d;
            stall_q    <= stall_d;
            pos_prev_q <= position;
        end
    end

endmodule
